// File: rtl/ofmd_rd_ctrl.sv
// OFMD readout controller: walks SRAM addresses 0..N-1 and streams the returned pixels
// through a 2-entry FIFO. out_valid/out_ready: a beat transfers on a clock edge where both are high.
module ofmd_rd_ctrl #(
   parameter int WIDTH      = 6,
   parameter int DATA_W     = 16,
   parameter int OFMD1_SIZE = 36,
   parameter int OFMD2_SIZE = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_5x5,
   output logic              busy,
   output logic              sram_rd_en,
   output logic [WIDTH-1:0]  sram_rd_addr,
   input  logic [DATA_W-1:0] sram_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic [1:0]        o_dbg_state
);

   // One extra bit so a size of exactly 2**WIDTH still fits the counters.
   localparam int CW = WIDTH + 1;
   localparam logic [CW-1:0] SZ1 = CW'(OFMD1_SIZE);
   localparam logic [CW-1:0] SZ2 = CW'(OFMD2_SIZE);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_size;
   logic [CW-1:0]       r_issue_cnt;
   logic [CW-1:0]       r_out_cnt;
   logic [WIDTH-1:0]    r_rd_addr;
   logic                r_inflight;
   logic [DATA_W-1:0]   r_mem [2];
   logic                r_wr_ptr;
   logic                r_rd_ptr;
   logic [1:0]          r_count;

   logic                w_start_ok;
   logic                w_pop;
   logic                w_push;
   logic                w_rd_en;
   logic                w_last_issue;
   logic                w_last_head;
   logic [2:0]          w_credit;

   assign w_start_ok   = (r_state == IDLE) && start;
   assign out_valid    = (r_count != 2'd0);
   assign w_pop        = out_valid && out_ready;
   assign w_push       = r_inflight;
   assign w_credit     = {1'b0, r_count} + {2'b00, r_inflight};
   // A pop this cycle frees the slot that a read issued now will fill next cycle.
   assign w_rd_en      = (r_state == RUN) && ((w_credit < 3'd2) || w_pop);
   assign w_last_issue = w_rd_en && (r_issue_cnt == (r_size - ONE));
   assign w_last_head  = out_valid && (r_out_cnt == (r_size - ONE));

   assign sram_rd_en   = w_rd_en;
   assign sram_rd_addr = w_rd_en ? r_issue_cnt[WIDTH-1:0] : r_rd_addr;
   assign out_data     = r_mem[r_rd_ptr];
   assign out_last     = w_last_head;
   assign done         = (r_state == FIN);
   assign busy         = (r_state != IDLE);
   assign o_dbg_state  = r_state;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last_issue) w_next = DRAIN;
         DRAIN:   if (w_pop && w_last_head) w_next = FIN;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_size      <= SZ1;
         r_issue_cnt <= '0;
         r_out_cnt   <= '0;
         r_rd_addr   <= '0;
         r_inflight  <= 1'b0;
         r_mem[0]    <= '0;
         r_mem[1]    <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_rd_en;
         if (w_start_ok) begin
            r_size      <= is_5x5 ? SZ2 : SZ1;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
         end else begin
            if (w_rd_en) r_issue_cnt <= r_issue_cnt + ONE;
            if (w_pop)   r_out_cnt   <= r_out_cnt + ONE;
         end
         if (w_rd_en) r_rd_addr <= r_issue_cnt[WIDTH-1:0];
         if (w_push) begin
            r_mem[r_wr_ptr] <= sram_rd_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ofmd_rd_ctrl.sv
// Bench for ofmd_rd_ctrl: table of readout scenarios plus a reset-abort sequence,
// checked against an SRAM model and an expected-data queue.
module tb_ofmd_rd_ctrl;

   localparam int WIDTH  = 6;
   localparam int DATA_W = 16;
   localparam int N1     = 36;
   localparam int N2     = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              is_5x5 = 1'b0;
   logic              busy;
   logic              sram_rd_en;
   logic [WIDTH-1:0]  sram_rd_addr;
   logic [DATA_W-1:0] sram_rd_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              done;
   logic [1:0]        o_dbg_state;

   ofmd_rd_ctrl #(.WIDTH(WIDTH), .DATA_W(DATA_W), .OFMD1_SIZE(N1), .OFMD2_SIZE(N2)) dut (
      .clk(clk), .rst(rst), .start(start), .is_5x5(is_5x5), .busy(busy),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .done(done), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- SRAM model: one-cycle read latency ----------------
   logic [DATA_W-1:0] mem [64];
   always @(posedge clk) begin
      if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
      else            sram_rd_data <= DATA_W'($urandom);
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int run_seq = 0;
   int seen_seq = 0;
   bit mon_en = 1'b0;
   int cur_n = N1;
   int exp_addr, issued, beats, first_en, last_en, first_valid, last_hs_cyc, done_cnt, done_cyc;
   bit hold_pending;
   logic [DATA_W-1:0] hold_data;
   logic hold_last;
   logic [DATA_W-1:0] exp_d;

   always @(negedge clk) begin
      if (run_seq != seen_seq) begin
         seen_seq = run_seq;
         exp_addr = 0; issued = 0; beats = 0;
         first_en = -1; last_en = -1; first_valid = -1; last_hs_cyc = -1;
         done_cnt = 0; done_cyc = -1; hold_pending = 1'b0;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (mon_en && rst) begin
         if (hold_pending) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("hold_last", 32'(out_last), 32'(hold_last));
         end
         if (sram_rd_en) begin
            chk("rd_addr", 32'(sram_rd_addr), exp_addr);
            exp_addr++;
            issued++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            chk("out_last", 32'(out_last), (beats == cur_n - 1) ? 1 : 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", beats + 1, cur_n);
            end else begin
               exp_d = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(exp_d));
            end
            beats++;
            last_hs_cyc = cyc;
         end
         chk("outstanding_le2", (issued - beats <= 2) ? 1 : 0, 1);
         hold_pending = out_valid && !out_ready;
         hold_data    = out_data;
         hold_last    = out_last;
      end
   end

   // ---------------- driver tasks ----------------
   typedef struct {
      logic sz;
      int   pct;
      logic toggle;
      logic start_mid;
      int   stall_at;
      int   abort_at;
      int   exp_n;
   } vec_t;

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_rd_en"}, 32'(sram_rd_en), 0);
      chk({tag, "_rd_addr"}, 32'(sram_rd_addr), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_last"}, 32'(out_last), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_out_data"}, 32'(out_data), 0);
      chk({tag, "_state"}, 32'(o_dbg_state), 0);
   endtask

   task automatic run_vec(input vec_t v);
      int rc;
      int stall_ctr;
      int start_cyc;
      cur_n = v.sz ? N2 : N1;
      exp_q.delete();
      for (int i = 0; i < cur_n; i++) exp_q.push_back(mem[i]);
      run_seq++;
      mon_en    = 1'b1;
      is_5x5    = v.sz;
      start     = 1'b1;
      out_ready = ($urandom_range(0, 99) < v.pct);
      @(posedge clk); #1;
      start_cyc = cyc;
      start     = 1'b0;
      rc        = 0;
      stall_ctr = 0;
      while (done_cnt == 0 && rc < 2000) begin
         if (v.abort_at >= 0 && beats >= v.abort_at) begin
            mon_en = 1'b0;
            run_seq++;
            rst = 1'b0;
            @(posedge clk); #1;
            check_idle_zero("abort");
            rst = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, 0);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_valid", 32'(out_valid), 0);
            out_ready = 1'b0;
            return;
         end
         if (v.stall_at >= 0 && beats >= v.stall_at && stall_ctr < 10) begin
            out_ready = 1'b0;
            stall_ctr++;
            if (stall_ctr == 10) begin
               chk("stall_issued", issued, v.stall_at + 2);
               chk("stall_rd_en", 32'(sram_rd_en), 0);
               chk("stall_data", 32'(out_data), 32'(mem[v.stall_at]));
            end
         end else begin
            out_ready = ($urandom_range(0, 99) < v.pct);
         end
         if (v.toggle && rc == 5) is_5x5 = ~is_5x5;
         start = v.start_mid && (rc == 8);
         @(posedge clk); #1;
         rc++;
      end
      start = 1'b0;
      out_ready = 1'b0;
      chk("done_seen", done_cnt, 1);
      chk("beats", beats, v.exp_n);
      chk("queue_empty", exp_q.size(), 0);
      chk("done_after_last", done_cyc, last_hs_cyc + 1);
      chk("first_rd_latency", first_en - start_cyc, 0);
      chk("first_valid_latency", first_valid - start_cyc, 2);
      chk("busy_after_fin", 32'(busy), 0);
      chk("done_one_cycle", 32'(done), 0);
      if (v.pct == 100 && v.stall_at < 0) begin
         chk("rd_contiguous", last_en - first_en, v.exp_n - 1);
         chk("out_1_per_cycle", last_hs_cyc - first_valid, v.exp_n - 1);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   vec_t vecs[7];
   vec_t abort_v;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = {8'(i + 1), 8'($urandom)};
      //          sz    pct  toggle start_mid stall abort exp_n
      vecs[0] = '{1'b0, 100, 1'b0, 1'b0,      -1,   -1,   N1};
      vecs[1] = '{1'b1, 100, 1'b1, 1'b0,      -1,   -1,   N2};
      vecs[2] = '{1'b0, 30,  1'b0, 1'b0,      -1,   -1,   N1};
      vecs[3] = '{1'b1, 30,  1'b1, 1'b0,      -1,   -1,   N2};
      vecs[4] = '{1'b0, 100, 1'b0, 1'b0,      4,    -1,   N1};
      vecs[5] = '{1'b1, 100, 1'b0, 1'b1,      -1,   -1,   N2};
      vecs[6] = '{1'b0, 70,  1'b1, 1'b1,      -1,   -1,   N1};
      abort_v = '{1'b0, 100, 1'b0, 1'b0,      -1,   10,   N1};

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      run_vec(abort_v);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      errors++;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ofmd_rd_ctrl.md
OFMD_RD_CTRL -- requirements
Module: ofmd_rd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning the SRAM read-address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the OFMD pixel width.
REQ-003 SHALL have parameter OFMD1_SIZE, default 36, meaning the element count of the 6x6 OFMD (3x3 kernel).
REQ-004 SHALL have parameter OFMD2_SIZE, default 16, meaning the element count of the 4x4 OFMD (5x5 kernel).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to read out a completed OFMD.
REQ-008 SHALL have port is_5x5, input, 1 bit: OFMD size select (1 = OFMD2_SIZE, 0 = OFMD1_SIZE), sampled on accepted start.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port sram_rd_en, output, 1 bit: OFMD SRAM read strobe.
REQ-011 SHALL have port sram_rd_addr, output, WIDTH bits: OFMD SRAM read address.
REQ-012 SHALL have port sram_rd_data, input, DATA_W bits: SRAM read data, valid exactly 1 cycle after sram_rd_en.
REQ-013 SHALL have port out_valid, output, 1 bit: stream data valid.
REQ-014 SHALL have port out_ready, input, 1 bit: stream consumer ready.
REQ-015 SHALL have port out_data, output, DATA_W bits: stream pixel.
REQ-016 SHALL have port out_last, output, 1 bit: high with the final element of the OFMD.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when the readout completes.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, FIN: IDLE->RUN on start; RUN->DRAIN when the last address issues; DRAIN->FIN on the handshake of the last element; FIN->IDLE unconditionally after 1 cycle.
REQ-019 SHALL ignore start outside IDLE; a start during RUN, DRAIN or FIN has no effect.
REQ-020 SHALL latch size N = is_5x5 ? OFMD2_SIZE : OFMD1_SIZE on accepted start and hold it until IDLE; is_5x5 changes mid-readout have no effect.
REQ-021 SHALL issue addresses 0..N-1 in ascending order, one per sram_rd_en, with no gaps or repeats; the address counter resets to 0 on entering RUN.
REQ-022 SHALL buffer returned data in a 2-entry FIFO; out_valid = FIFO non-empty; out_data = FIFO head; a pop occurs when out_valid && out_ready.
REQ-023 SHALL assert sram_rd_en only in RUN, and only when (occupancy + in-flight reads) < 2 or a pop occurs in the same cycle; the FIFO never overflows and no data is dropped.
REQ-024 SHALL sustain 1 element/cycle while out_ready is held high.
REQ-025 SHALL assert sram_rd_en in the first cycle after an accepted start (first RUN cycle), with sram_rd_addr = 0.
REQ-026 SHALL assert out_valid for element 0 two cycles after start.
REQ-027 SHALL hold out_valid, out_data and out_last stable while out_valid && !out_ready.
REQ-028 SHALL assert out_last only while the FIFO head is element N-1.
REQ-029 SHALL pulse done for exactly 1 cycle, in FIN, i.e. the cycle after the final handshake.
REQ-030 SHALL hold sram_rd_addr at its last issued value when sram_rd_en is low; the value is don't-care.

Reset
REQ-031 SHALL, while rst = 0 at a clock edge, apply: state IDLE, FIFO empty, in-flight cleared, address counter 0, latched size OFMD1_SIZE, and outputs busy, sram_rd_en, out_valid, out_last, done = 0 and sram_rd_addr, out_data = 0.
REQ-032 SHALL, on reset mid-readout, abort the readout, discard any returning SRAM data and not pulse done; the next start begins again from address 0.

Verification
REQ-033 SHALL be verified with a 6x6 readout: is_5x5 = 0, start, out_ready = 1 -> addresses 0..35 on consecutive cycles, 36 beats, out_last on beat 36, done 1 cycle later, busy low after FIN.
REQ-034 SHALL be verified with a 4x4 readout: is_5x5 = 1 -> exactly 16 beats, out_last on beat 16; toggling is_5x5 mid-run changes nothing.
REQ-035 SHALL be verified under backpressure: out_ready random at 30% -> data matches SRAM[0..N-1] in order, no loss or duplicate, and occupancy + in-flight is never greater than 2.
REQ-036 SHALL be verified with a stall: out_ready = 0 from beat 5 for 10 cycles -> sram_rd_en stops after 2 outstanding, out_data stays at element 4, and the stream resumes at element 4 with no gap.
REQ-037 SHALL be verified with start asserted during RUN -> ignored, exactly one done pulse.
REQ-038 SHALL be verified with rst = 0 at beat 10 -> all outputs 0 the next cycle and no done; a new start reads from address 0.
